// File: rtl/ram_banked2port.sv
// Simple dual-port RAM with per-lane write mask, RDLAT-cycle read pipeline with rd_valid and post-reset zero-init.
// No backpressure: init_busy blocks all access; define RAM_RDW_BYPASS_EN for write-to-read bypass on same-address collisions.
module ram_banked2port #(
   parameter int BDADDR = 12,
   parameter int BDWORD = 2048,
   parameter int BDMASK = 64,
   parameter int RDLAT  = 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic              init_busy,
   input  logic              rd_en,
   input  logic [BDADDR-1:0] rd_addr,
   output logic [BDWORD-1:0] rd_word,
   output logic              rd_valid,
   input  logic              wr_en,
   input  logic [BDADDR-1:0] wr_addr,
   input  logic [BDWORD-1:0] wr_word,
   input  logic [BDMASK-1:0] wr_mask
);

   localparam int W     = BDWORD / BDMASK;
   localparam int DEPTH = 2 ** BDADDR;

   if ((BDWORD % BDMASK) != 0 || RDLAT < 1) begin : g_param_check
      $error("ram_banked2port: BDWORD must divide by BDMASK and RDLAT must be >= 1");
   end

   typedef enum logic {INIT, READY} state_t;

   state_t              state;
   logic [BDADDR-1:0]   init_cnt;

   logic                mem_we;
   logic [BDADDR-1:0]   mem_waddr;
   logic [BDWORD-1:0]   mem_wdata;
   logic [BDMASK-1:0]   mem_wmask;
   logic [BDWORD-1:0]   mem [DEPTH];

   logic                rd_acc;
   logic [BDWORD-1:0]   rd_raw;
   logic [RDLAT-1:0]    pipe_vld;
   logic [BDWORD-1:0]   pipe_dat [RDLAT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= INIT;
         init_cnt  <= '0;
         init_busy <= 1'b1;
      end else begin
         case (state)
            INIT: begin
               init_cnt <= init_cnt + 1'b1;
               if (init_cnt == {BDADDR{1'b1}}) begin
                  state     <= READY;
                  init_busy <= 1'b0;
               end
            end
            READY: begin
               state <= READY;
            end
            default: begin
               state     <= INIT;
               init_busy <= 1'b1;
            end
         endcase
      end
   end

   // The init sequencer owns the write port until READY; user writes are dropped.
   always_comb begin
      mem_we    = wr_en;
      mem_waddr = wr_addr;
      mem_wdata = wr_word;
      mem_wmask = wr_mask;
      if (state == INIT) begin
         mem_we    = 1'b1;
         mem_waddr = init_cnt;
         mem_wdata = '0;
         mem_wmask = '1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < BDMASK; i++) begin
            if (mem_wmask[i]) mem[mem_waddr][i*W +: W] <= mem_wdata[i*W +: W];
         end
      end
   end

   assign rd_acc = rd_en && (state == READY);

`ifdef RAM_RDW_BYPASS_EN
   always_comb begin
      rd_raw = mem[rd_addr];
      if (wr_en && (state == READY) && (wr_addr == rd_addr)) begin
         for (int i = 0; i < BDMASK; i++) begin
            if (wr_mask[i]) rd_raw[i*W +: W] = wr_word[i*W +: W];
         end
      end
   end
`else
   // Non-blocking array update gives read-before-write on collisions.
   assign rd_raw = mem[rd_addr];
`endif

   // Stages load only behind a valid bit so rd_word holds between bursts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_vld <= '0;
         for (int i = 0; i < RDLAT; i++) pipe_dat[i] <= '0;
      end else begin
         pipe_vld[0] <= rd_acc;
         if (rd_acc) pipe_dat[0] <= rd_raw;
         for (int i = 1; i < RDLAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            if (pipe_vld[i-1]) pipe_dat[i] <= pipe_dat[i-1];
         end
      end
   end

   assign rd_valid = pipe_vld[RDLAT-1];
   assign rd_word  = pipe_dat[RDLAT-1];

endmodule

// File: tb/tb_ram_banked2port.sv
// Directed bench for ram_banked2port (BDADDR=4, BDWORD=32, BDMASK=4, RDLAT=2) with a read scoreboard.
module tb_ram_banked2port;

   localparam int BDADDR = 4;
   localparam int BDWORD = 32;
   localparam int BDMASK = 4;
   localparam int RDLAT  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              init_busy;
   logic              rd_en;
   logic [BDADDR-1:0] rd_addr;
   logic [BDWORD-1:0] rd_word;
   logic              rd_valid;
   logic              wr_en;
   logic [BDADDR-1:0] wr_addr;
   logic [BDWORD-1:0] wr_word;
   logic [BDMASK-1:0] wr_mask;

   typedef struct packed {
      logic [31:0] w;
      int          c;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   errs    = 0;
   int   cyc     = 0;
   int   n;

   ram_banked2port #(.BDADDR(BDADDR), .BDWORD(BDWORD), .BDMASK(BDMASK), .RDLAT(RDLAT)) dut (
      .clk(clk), .rst(rst), .init_busy(init_busy),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_word(rd_word), .rd_valid(rd_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_word(wr_word), .wr_mask(wr_mask)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Output monitor: every rd_valid must match the head of the scoreboard, on time.
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_rd_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("rd_word", rd_word, e.w);
            chk("rd_latency", cyc, e.c + RDLAT - 1);
         end
      end
   end

   task automatic drive(input bit re, input logic [3:0] ra, input bit we, input logic [3:0] wa,
                        input logic [31:0] wd, input logic [3:0] wm, input bit push, input logic [31:0] exp);
      exp_t e;
      rd_en   = re;
      rd_addr = ra;
      wr_en   = we;
      wr_addr = wa;
      wr_word = wd;
      wr_mask = wm;
      if (push) begin
         e.w = exp;
         e.c = cyc + 1;
         q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic idle();
      drive(1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 32'd0);
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
      chk("drain_timeout", q.size(), 32'd0);
   endtask

   task automatic count_busy(output int cnt, input bit check_rdv);
      cnt = 0;
      for (int k = 0; k < 100 && init_busy === 1'b1; k++) begin
         if (check_rdv) chk("init_rd_valid", {31'd0, rd_valid}, 32'd0);
         cnt++;
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1;
      rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_word = '0; wr_mask = '0;
      repeat (2) @(negedge clk);
      chk("rst_init_busy", {31'd0, init_busy}, 32'd1);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_rd_word", rd_word, 32'd0);

      // Init length and zeroed contents.
      rst = 1'b0;
      count_busy(n, 1'b0);
      chk("init_cycles", n, 32'd16);
      for (int a = 0; a < 16; a++) drive(1'b1, 4'(a), 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 32'h0);
      idle();
      drain();

      // Full and partial masked writes.
      drive(1'b0, 4'd0, 1'b1, 4'd3, 32'hDEADBEEF, 4'b1111, 1'b0, 32'd0);
      drive(1'b1, 4'd3, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 32'hDEADBEEF);
      drive(1'b0, 4'd0, 1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0, 32'd0);
      drive(1'b1, 4'd3, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 32'hDE22BE44);
      drive(1'b0, 4'd0, 1'b1, 4'd3, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'd0);
      drive(1'b1, 4'd3, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 32'hDE22BE44);
      idle();
      drain();

      // Back-to-back reads and hold of rd_word afterwards.
      for (int a = 0; a < 16; a++) drive(1'b0, 4'd0, 1'b1, 4'(a), 32'h1000 + a, 4'b1111, 1'b0, 32'd0);
      for (int a = 0; a < 16; a++) drive(1'b1, 4'(a), 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 32'h1000 + a);
      idle();
      drain();
      idle();
      idle();
      chk("idle_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("hold_rd_word", rd_word, 32'h0000100F);

      // Same-cycle read/write collisions and independent addresses.
      drive(1'b0, 4'd0, 1'b1, 4'd5, 32'h0, 4'b1111, 1'b0, 32'd0);
`ifdef RAM_RDW_BYPASS_EN
      drive(1'b1, 4'd5, 1'b1, 4'd5, 32'hA5A5A5A5, 4'b1111, 1'b1, 32'hA5A5A5A5);
`else
      drive(1'b1, 4'd5, 1'b1, 4'd5, 32'hA5A5A5A5, 4'b1111, 1'b1, 32'h00000000);
`endif
      drive(1'b1, 4'd5, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 32'hA5A5A5A5);
      drive(1'b0, 4'd0, 1'b1, 4'd5, 32'h0, 4'b1111, 1'b0, 32'd0);
`ifdef RAM_RDW_BYPASS_EN
      drive(1'b1, 4'd5, 1'b1, 4'd5, 32'hA5A5A5A5, 4'b0011, 1'b1, 32'h0000A5A5);
`else
      drive(1'b1, 4'd5, 1'b1, 4'd5, 32'hA5A5A5A5, 4'b0011, 1'b1, 32'h00000000);
`endif
      drive(1'b1, 4'd5, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 32'h0000A5A5);
      drive(1'b1, 4'd6, 1'b1, 4'd7, 32'h77777777, 4'b1111, 1'b1, 32'h00001006);
      drive(1'b1, 4'd7, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 32'h77777777);
      idle();
      drain();

      // Reset in the middle of INIT, with writes and reads pressed during the new INIT.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      rd_en = 1'b1; rd_addr = 4'd2;
      wr_en = 1'b1; wr_addr = 4'd2; wr_word = 32'hFFFFFFFF; wr_mask = 4'b1111;
      @(negedge clk);
      chk("rst2_init_busy", {31'd0, init_busy}, 32'd1);
      rst = 1'b0;
      count_busy(n, 1'b1);
      rd_en = 1'b0; wr_en = 1'b0;
      chk("reinit_cycles", n, 32'd16);
      drive(1'b1, 4'd2, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 32'h0);
      drive(1'b1, 4'd3, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 32'h0);
      idle();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
